// File: rtl/mac_kbd_link_pkg.sv
// rtl/mac_kbd_link_pkg.sv - shared types and constants for the Mac keyboard serial link
package mac_kbd_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD_SHIFT = 3'd1,
        ST_CMD_DONE  = 3'd2,
        ST_WAIT_RSP  = 3'd3,
        ST_RSP_SHIFT = 3'd4,
        ST_GAP_HOLD  = 3'd5
    } link_state_e;

    localparam int   KBD_BITS   = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/mac_kbd_link_ctrl_bit_clk.sv
// rtl/mac_kbd_link_ctrl_bit_clk.sv - half-period divider generating the 8-bit CB1 burst
module kbd_bit_clk
    import mac_kbd_link_pkg::*;
#(
    parameter int HALF_PERIOD = 40
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic start_i,
    input  logic stop_i,
    output logic cb1_o,
    output logic fall_pulse_o,
    output logic rise_pulse_o,
    output logic bit_done_o
);

    localparam int            TW         = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(HALF_PERIOD - 1);
    localparam logic [2:0]    LAST_BIT   = 3'(KBD_BITS - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic          done_q, done_d;
    logic          high_q, high_d;
    logic          cb1_q, cb1_d;
    logic          half_end;

    // Edge pulses describe the transition the registers take on this ce cycle.
    always_comb begin
        half_end     = ce && !done_q && (timer_q == TIMER_LAST);
        rise_pulse_o = half_end && !high_q;
        fall_pulse_o = half_end && high_q && (bit_q != LAST_BIT);
        bit_done_o   = half_end && high_q && (bit_q == LAST_BIT);
        cb1_o        = cb1_q;
    end

    // Next-state: stop wins over start; the bit counter saturates with the done flag set.
    always_comb begin
        timer_d = timer_q;
        bit_d   = bit_q;
        done_d  = done_q;
        high_d  = high_q;
        cb1_d   = cb1_q;
        if (ce) begin
            if (stop_i) begin
                done_d  = 1'b1;
                timer_d = '0;
                cb1_d   = IDLE_LEVEL;
            end else if (start_i) begin
                done_d  = 1'b0;
                timer_d = '0;
                bit_d   = '0;
                high_d  = 1'b0;
                cb1_d   = ~IDLE_LEVEL;
            end else if (!done_q) begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    if (!high_q) begin
                        high_d = 1'b1;
                        cb1_d  = IDLE_LEVEL;
                    end else if (bit_q == LAST_BIT) begin
                        done_d = 1'b1;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        high_d = 1'b0;
                        cb1_d  = ~IDLE_LEVEL;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        end
    end

    // Divider state registers; idle means done with CB1 parked high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
            bit_q   <= '0;
            done_q  <= 1'b1;
            high_q  <= 1'b1;
            cb1_q   <= IDLE_LEVEL;
        end else begin
            timer_q <= timer_d;
            bit_q   <= bit_d;
            done_q  <= done_d;
            high_q  <= high_d;
            cb1_q   <= cb1_d;
        end
    end

endmodule

// File: rtl/mac_kbd_link_ctrl.sv
// rtl/mac_kbd_link_ctrl.sv - Mac Plus keyboard link sequencer between VIA shift register and responder
module mac_kbd_link_ctrl
    import mac_kbd_link_pkg::*;
#(
    parameter int          HALF_PERIOD = 40,
    parameter logic [22:0] RSP_TIMEOUT = 23'h500000,
    parameter int          GAP         = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       host_sending,
    input  logic       cb2_host,
    output logic       cb1,
    output logic       cb2_kbd,
    output logic [7:0] cmd_data,
    output logic       cmd_strobe,
    input  logic [7:0] rsp_data,
    input  logic       rsp_strobe,
    output logic       busy,
    output logic       rsp_drop
);

    localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [22:0]   TO_LAST  = RSP_TIMEOUT - 23'd1;

    link_state_e   state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    cmd_data_q, cmd_data_d;
    logic          cmd_strobe_q, cmd_strobe_d;
    logic          cb2_q, cb2_d;
    logic          drop_q, drop_d;
    logic [22:0]   to_q, to_d;
    logic [GW-1:0] gap_q, gap_d;

    logic clk_start, clk_stop, fall_pulse, rise_pulse, bit_done;

    kbd_bit_clk #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_bit_clk (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .start_i      (clk_start),
        .stop_i       (clk_stop),
        .cb1_o        (cb1),
        .fall_pulse_o (fall_pulse),
        .rise_pulse_o (rise_pulse),
        .bit_done_o   (bit_done)
    );

    // Transaction FSM: host abort/re-command beats a reply, which beats the timeout.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cmd_data_d   = cmd_data_q;
        cmd_strobe_d = cmd_strobe_q;
        cb2_d        = cb2_q;
        drop_d       = drop_q;
        to_d         = to_q;
        gap_d        = gap_q;
        clk_start    = 1'b0;
        clk_stop     = 1'b0;
        if (ce) begin
            cmd_strobe_d = 1'b0;
            drop_d       = rsp_strobe && (state_q != ST_WAIT_RSP);
            case (state_q)
                ST_IDLE: begin
                    if (host_sending) begin
                        state_d   = ST_CMD_SHIFT;
                        shreg_d   = '0;
                        clk_start = 1'b1;
                    end
                end
                ST_CMD_SHIFT: begin
                    if (!host_sending) begin
                        state_d  = ST_IDLE;
                        clk_stop = 1'b1;
                    end else begin
                        if (rise_pulse) shreg_d = {shreg_q[6:0], cb2_host};
                        if (bit_done)   state_d = ST_CMD_DONE;
                    end
                end
                ST_CMD_DONE: begin
                    cmd_data_d   = shreg_q;
                    cmd_strobe_d = 1'b1;
                    to_d         = '0;
                    state_d      = ST_WAIT_RSP;
                end
                ST_WAIT_RSP: begin
                    if (host_sending) begin
                        state_d   = ST_CMD_SHIFT;
                        shreg_d   = '0;
                        clk_start = 1'b1;
                    end else if (rsp_strobe) begin
                        state_d   = ST_RSP_SHIFT;
                        cb2_d     = rsp_data[7];
                        shreg_d   = {rsp_data[6:0], IDLE_LEVEL};
                        clk_start = 1'b1;
                    end else if (to_q == TO_LAST) begin
                        state_d = ST_GAP_HOLD;
                        gap_d   = '0;
                    end else begin
                        to_d = to_q + 23'd1;
                    end
                end
                ST_RSP_SHIFT: begin
                    if (fall_pulse) begin
                        cb2_d   = shreg_q[7];
                        shreg_d = {shreg_q[6:0], IDLE_LEVEL};
                    end
                    if (bit_done) begin
                        cb2_d   = IDLE_LEVEL;
                        state_d = ST_GAP_HOLD;
                        gap_d   = '0;
                    end
                end
                ST_GAP_HOLD: begin
                    if (gap_q == GAP_LAST) state_d = ST_IDLE;
                    else                   gap_d   = gap_q + 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers; asynchronous reset parks the link idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            cmd_data_q   <= '0;
            cmd_strobe_q <= 1'b0;
            cb2_q        <= IDLE_LEVEL;
            drop_q       <= 1'b0;
            to_q         <= '0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cmd_data_q   <= cmd_data_d;
            cmd_strobe_q <= cmd_strobe_d;
            cb2_q        <= cb2_d;
            drop_q       <= drop_d;
            to_q         <= to_d;
            gap_q        <= gap_d;
        end
    end

    // Output mapping.
    always_comb begin
        cb2_kbd    = cb2_q;
        cmd_data   = cmd_data_q;
        cmd_strobe = cmd_strobe_q;
        rsp_drop   = drop_q;
        busy       = (state_q != ST_IDLE);
    end

endmodule
